// File: rtl/seq_compare_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM encoding,
// default operand width and the digit-counter width helper.
package seq_compare_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter width for ndig scan steps; never narrower than one bit.
  function automatic int cnt_width(input int ndig);
    int w;
    if (ndig <= 2) begin
      w = 1;
    end else begin
      w = $clog2(ndig);
    end
    return w;
  endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational DIGIT-bit comparator; msb_flip inverts the digit MSB so an
// unsigned compare of the top digit yields two's-complement order.
module cmp_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] da,
  input  logic [DIGIT-1:0] db,
  input  logic             msb_flip,
  output logic             diff,
  output logic             a_lt_b
);

  logic [DIGIT-1:0] flip_s;
  logic [DIGIT-1:0] da_s;
  logic [DIGIT-1:0] db_s;

  // Offset-binary conversion of the digits followed by the plain compare.
  always_comb begin
    flip_s            = '0;
    flip_s[DIGIT-1]   = msb_flip;
    da_s              = da ^ flip_s;
    db_s              = db ^ flip_s;
    diff              = (da_s != db_s);
    a_lt_b            = (da_s < db_s);
  end

endmodule

// File: rtl/seq_compare_unit.sv
// Multi-cycle signed/unsigned comparator scanning operands MSB-first one digit
// per cycle. Optional early exit on first differing digit: SEQ_COMPARE_EARLY_EXIT_EN.
module seq_compare_unit
  import seq_compare_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             eq,
  output logic             lte
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

  state_e           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             signed_r;
  logic             decided_r;
  logic             lt_acc_r;
  logic [CW-1:0]    cnt_r;

  logic             msb_flip_s;
  logic             diff_s;
  logic             a_lt_b_s;
  logic             decided_nx_s;
  logic             lt_nx_s;
  logic             finish_s;

  // Operands shift left each step, so the current digit is always on top.
  cmp_digit #(.DIGIT(DIGIT)) u_cmp_digit (
    .da       (a_r[WIDTH-1 -: DIGIT]),
    .db       (b_r[WIDTH-1 -: DIGIT]),
    .msb_flip (msb_flip_s),
    .diff     (diff_s),
    .a_lt_b   (a_lt_b_s)
  );

  // Next-step decision state and scan termination.
  always_comb begin
    msb_flip_s   = signed_r & (cnt_r == '0);
    decided_nx_s = decided_r | diff_s;
    if (decided_r) begin
      lt_nx_s = lt_acc_r;
    end else if (diff_s) begin
      lt_nx_s = a_lt_b_s;
    end else begin
      lt_nx_s = 1'b0;
    end
`ifdef SEQ_COMPARE_EARLY_EXIT_EN
    finish_s = (cnt_r == LAST_CNT) | (~decided_r & diff_s);
`else
    finish_s = (cnt_r == LAST_CNT);
`endif
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      signed_r  <= 1'b0;
      decided_r <= 1'b0;
      lt_acc_r  <= 1'b0;
      cnt_r     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      lte       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r       <= a;
            b_r       <= b;
            signed_r  <= signed_mode;
            decided_r <= 1'b0;
            lt_acc_r  <= 1'b0;
            cnt_r     <= '0;
            in_ready  <= 1'b0;
            state_r   <= SCAN;
          end else begin
            in_ready  <= 1'b1;
          end
        end
        SCAN: begin
          a_r       <= a_r << DIGIT;
          b_r       <= b_r << DIGIT;
          cnt_r     <= cnt_r + CW'(1);
          decided_r <= decided_nx_s;
          lt_acc_r  <= lt_nx_s;
          if (finish_s) begin
            out_valid <= 1'b1;
            lt        <= lt_nx_s;
            eq        <= ~decided_nx_s;
            lte       <= lt_nx_s | ~decided_nx_s;
            state_r   <= DONE;
          end else begin
            state_r   <= SCAN;
          end
        end
        DONE: begin
          // Release the result only on the consumer handshake; re-accept a cycle later.
          if (out_ready) begin
            out_valid <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
            lte       <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            state_r   <= DONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
